// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetch requests under a
// two-slot credit limit, tracks in-flight addresses, buffers returned words
// in a 2-entry FIFO and presents the head with decoded immediate fields.
// Redirects flush buffered work and mark in-flight responses for discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [11:0] imm_input,
    output logic [19:0] imm_input_uj
);

    // 12-bit immediate: B-type and S-type scramble, I-type otherwise
    function automatic logic [11:0] decode_imm12(input logic [31:0] i);
        logic [11:0] r;
        case (i[6:0])
            7'b1100011: r = {i[31], i[7], i[30:25], i[11:8]};
            7'b0100011: r = {i[31:25], i[11:7]};
            default:    r = i[31:20];
        endcase
        return r;
    endfunction

    // 20-bit immediate: J-type scramble for JAL, U-type otherwise
    function automatic logic [19:0] decode_imm20(input logic [31:0] i);
        logic [19:0] r;
        case (i[6:0])
            7'b1101111: r = {i[31], i[19:12], i[20], i[30:21]};
            default:    r = i[31:12];
        endcase
        return r;
    endfunction

    // Architectural state
    logic [31:0] pc_q, pc_d;
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];
    logic        fifo_rd_q, fifo_rd_d;
    logic        fifo_wr_q, fifo_wr_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [31:0] infl_addr_q  [2];
    logic        infl_rd_q, infl_rd_d;
    logic        infl_wr_q, infl_wr_d;
    logic [1:0]  outst_q, outst_d;
    logic [1:0]  discard_q, discard_d;

    // Handshake qualifiers
    logic        rsp_s;
    logic        credit_ok_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;
    logic        fifo_we_s;
    logic        infl_we_s;
    logic [2:0]  credit_sum_s;
    logic        redirect_lsb_unused_s;

    // Low target bits are architecturally ignored
    assign redirect_lsb_unused_s = ^redirect_pc[1:0];

    // A response with nothing outstanding belongs to a request that was
    // wiped by reset, so it is not a response at all.
    assign rsp_s        = imem_rvalid && (outst_q != 2'd0);
    assign credit_sum_s = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
    assign credit_ok_s  = (credit_sum_s < 3'd2);
    assign imem_req     = rst_n && !redirect && credit_ok_s;
    assign imem_addr    = pc_q;
    assign accept_s     = imem_req && imem_gnt;
    assign out_valid    = rst_n && (fifo_cnt_q != 2'd0);
    assign pop_s        = out_valid && out_ready;
    assign push_s       = rsp_s && (discard_q == 2'd0);
    assign fifo_we_s    = push_s && !redirect;
    assign infl_we_s    = accept_s;

    // Head-of-FIFO presentation and decode
    assign out_instr    = fifo_instr_q[fifo_rd_q];
    assign out_pc       = fifo_pc_q[fifo_rd_q];
    assign out_opcode   = out_instr[6:0];
    assign imm_input    = decode_imm12(out_instr);
    assign imm_input_uj = decode_imm20(out_instr);

    // Next-state logic: redirect overrides issue, response and pop handling
    always_comb begin
        pc_d       = pc_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q;
        infl_rd_d  = infl_rd_q;
        infl_wr_d  = infl_wr_q;
        outst_d    = outst_q;
        discard_d  = discard_q;

        // Every real response retires the oldest in-flight address
        if (rsp_s) begin
            infl_rd_d = ~infl_rd_q;
        end else begin
            infl_rd_d = infl_rd_q;
        end

        if (redirect) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            fifo_rd_d  = 1'b0;
            fifo_wr_d  = 1'b0;
            fifo_cnt_d = 2'd0;
            outst_d    = outst_q - {1'b0, rsp_s};
            discard_d  = outst_q - {1'b0, rsp_s};
        end else begin
            if (accept_s) begin
                pc_d      = pc_q + 32'd4;
                infl_wr_d = ~infl_wr_q;
            end else begin
                pc_d      = pc_q;
                infl_wr_d = infl_wr_q;
            end

            case ({accept_s, rsp_s})
                2'b10:   outst_d = outst_q + 2'd1;
                2'b01:   outst_d = outst_q - 2'd1;
                default: outst_d = outst_q;
            endcase

            if (rsp_s && (discard_q != 2'd0)) begin
                discard_d = discard_q - 2'd1;
            end else begin
                discard_d = discard_q;
            end

            if (push_s) begin
                fifo_wr_d = ~fifo_wr_q;
            end else begin
                fifo_wr_d = fifo_wr_q;
            end

            if (pop_s) begin
                fifo_rd_d = ~fifo_rd_q;
            end else begin
                fifo_rd_d = fifo_rd_q;
            end

            case ({push_s, pop_s})
                2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end
    end

    // State registers and FIFO/in-flight storage, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            infl_rd_q  <= 1'b0;
            infl_wr_q  <= 1'b0;
            outst_q    <= 2'd0;
            discard_q  <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                fifo_instr_q[k] <= 32'd0;
                fifo_pc_q[k]    <= 32'd0;
                infl_addr_q[k]  <= 32'd0;
            end
        end else begin
            pc_q       <= pc_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            infl_rd_q  <= infl_rd_d;
            infl_wr_q  <= infl_wr_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if (fifo_we_s) begin
                fifo_instr_q[fifo_wr_q] <= imem_rdata;
                fifo_pc_q[fifo_wr_q]    <= infl_addr_q[infl_rd_q];
            end
            if (infl_we_s) begin
                infl_addr_q[infl_wr_q] <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order memory responder returns a
// word derived from each accepted address; scenario tasks drive inputs on
// the falling edge and compare outputs 1 time unit later.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [11:0] imm_input;
    logic [19:0] imm_input_uj;

    int checks = 0;
    int errors = 0;

    // Responder state
    logic        resp_en;
    logic        rsp_clear;
    logic [31:0] rq_addr [8];
    logic [2:0]  rq_wr = 3'd0;
    logic [2:0]  rq_rd = 3'd0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .imm_input    (imm_input),
        .imm_input_uj (imm_input_uj)
    );

    always #5 clk = ~clk;

    // Memory contents: a few hand-picked encodings, otherwise an ADDI-like tag
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        case (a)
            32'h0000_0200: w = 32'hFE00_0EE3;
            32'h0000_0204: w = 32'h0080_006F;
            32'h0000_0208: w = 32'h1234_52B7;
            32'h0000_020C: w = 32'h5400_0AA3;
            default:       w = {a[23:0], 8'h13};
        endcase
        return w;
    endfunction

    // In-order responder: records accepted addresses, answers when enabled
    always @(posedge clk) begin
        if (rsp_clear) begin
            rq_wr <= 3'd0;
            rq_rd <= 3'd0;
        end else begin
            if (imem_rvalid) rq_rd <= rq_rd + 3'd1;
            if (imem_req && imem_gnt) begin
                rq_addr[rq_wr] <= imem_addr;
                rq_wr <= rq_wr + 3'd1;
            end
        end
    end

    assign imem_rvalid = resp_en && (rq_wr != rq_rd);
    assign imem_rdata  = word_at(rq_addr[rq_rd]);

    task automatic do_reset;
        rst_n = 1'b0; imem_gnt = 1'b0; resp_en = 1'b0; out_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0; rsp_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rsp_clear = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; imem_gnt = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
        redirect = 1'b0; redirect_pc = 32'd0; rsp_clear = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req c%0d: got %b expected 0", c, imem_req); end checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ov c%0d: got %b expected 0", c, out_valid); end checks++;
            @(negedge clk);
        end
        rsp_clear = 1'b0; rst_n = 1'b1; imem_gnt = 1'b0;
        #1;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr: got %h expected 00000000", imem_addr); end checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_first_ov: got %b expected 0", out_valid); end checks++;
        @(negedge clk);
    endtask

    task automatic test_stream;
        logic        e_req  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] e_addr [9] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10, 32'h14, 32'h0};
        logic        e_ov   [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_pc   [9] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'hC, 32'h0, 32'h10};
        do_reset();
        imem_gnt = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (imem_req !== e_req[c]) begin errors++; $display("FAIL stream_req c%0d: got %b expected %b", c, imem_req, e_req[c]); end checks++;
            if (e_req[c]) begin
                if (imem_addr !== e_addr[c]) begin errors++; $display("FAIL stream_addr c%0d: got %h expected %h", c, imem_addr, e_addr[c]); end checks++;
            end
            if (out_valid !== e_ov[c]) begin errors++; $display("FAIL stream_ov c%0d: got %b expected %b", c, out_valid, e_ov[c]); end checks++;
            if (e_ov[c]) begin
                if (out_pc !== e_pc[c]) begin errors++; $display("FAIL stream_pc c%0d: got %h expected %h", c, out_pc, e_pc[c]); end checks++;
                if (out_instr !== word_at(e_pc[c])) begin errors++; $display("FAIL stream_instr c%0d: got %h expected %h", c, out_instr, word_at(e_pc[c])); end checks++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        imem_gnt = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int c = 2; c < 5; c++) begin
            #1;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req c%0d: got %b expected 0", c, imem_req); end checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_ov c%0d: got %b expected 1", c, out_valid); end checks++;
            if (out_pc !== 32'h0) begin errors++; $display("FAIL bp_pc c%0d: got %h expected 00000000", c, out_pc); end checks++;
            if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL bp_instr c%0d: got %h expected 00000013", c, out_instr); end checks++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_c5: got %b expected 0", imem_req); end checks++;
        @(negedge clk);
        #1;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req: got %b expected 1", imem_req); end checks++;
        if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume_addr: got %h expected 00000008", imem_addr); end checks++;
        if (out_pc !== 32'h4) begin errors++; $display("FAIL bp_resume_pc: got %h expected 00000004", out_pc); end checks++;
        @(negedge clk);
    endtask

    task automatic test_redirect;
        do_reset();
        imem_gnt = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0103; resp_en = 1'b1;
        #1;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", imem_req); end checks++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_next_req: got %b expected 1", imem_req); end checks++;
        if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_next_addr: got %h expected 00000100", imem_addr); end checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_ov_c3: got %b expected 0", out_valid); end checks++;
        @(negedge clk);
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_ov_c4: got %b expected 0", out_valid); end checks++;
        if (imem_addr !== 32'h104) begin errors++; $display("FAIL redir_addr_c4: got %h expected 00000104", imem_addr); end checks++;
        @(negedge clk);
        #1;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_ov_c5: got %b expected 1", out_valid); end checks++;
        if (out_pc !== 32'h100) begin errors++; $display("FAIL redir_first_pc: got %h expected 00000100", out_pc); end checks++;
        if (out_instr !== word_at(32'h100)) begin errors++; $display("FAIL redir_first_instr: got %h expected %h", out_instr, word_at(32'h100)); end checks++;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h300; resp_en = 1'b0;
        #1;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req_1: got %b expected 0", imem_req); end checks++;
        @(negedge clk);
        redirect_pc = 32'h400;
        #1;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req_2: got %b expected 0", imem_req); end checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_flush_ov: got %b expected 0", out_valid); end checks++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_last_req: got %b expected 1", imem_req); end checks++;
        if (imem_addr !== 32'h400) begin errors++; $display("FAIL b2b_last_addr: got %h expected 00000400", imem_addr); end checks++;
        @(negedge clk);
    endtask

    task automatic test_decode;
        do_reset();
        imem_gnt = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        if (imem_addr !== 32'h200) begin errors++; $display("FAIL dec_addr: got %h expected 00000200", imem_addr); end checks++;
        @(negedge clk);
        @(negedge clk);
        #1;
        if (out_pc !== 32'h200) begin errors++; $display("FAIL dec_b_pc: got %h expected 00000200", out_pc); end checks++;
        if (out_opcode !== 7'h63) begin errors++; $display("FAIL dec_b_opcode: got %h expected 63", out_opcode); end checks++;
        if (imm_input !== 12'hFFE) begin errors++; $display("FAIL dec_b_imm: got %h expected ffe", imm_input); end checks++;
        if (imm_input_uj !== 20'hFE000) begin errors++; $display("FAIL dec_b_uj: got %h expected fe000", imm_input_uj); end checks++;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        if (out_opcode !== 7'h6F) begin errors++; $display("FAIL dec_jal_opcode: got %h expected 6f", out_opcode); end checks++;
        if (imm_input_uj !== 20'h00004) begin errors++; $display("FAIL dec_jal_uj: got %h expected 00004", imm_input_uj); end checks++;
        if (imm_input !== 12'h008) begin errors++; $display("FAIL dec_jal_imm: got %h expected 008", imm_input); end checks++;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        if (out_pc !== 32'h208) begin errors++; $display("FAIL dec_lui_pc: got %h expected 00000208", out_pc); end checks++;
        if (imm_input_uj !== 20'h12345) begin errors++; $display("FAIL dec_lui_uj: got %h expected 12345", imm_input_uj); end checks++;
        if (imm_input !== 12'h123) begin errors++; $display("FAIL dec_lui_imm: got %h expected 123", imm_input); end checks++;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        if (out_opcode !== 7'h23) begin errors++; $display("FAIL dec_s_opcode: got %h expected 23", out_opcode); end checks++;
        if (imm_input !== 12'h555) begin errors++; $display("FAIL dec_s_imm: got %h expected 555", imm_input); end checks++;
        @(negedge clk);
    endtask

    task automatic test_reset_midop;
        do_reset();
        imem_gnt = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; rst_n = 1'b0;
        #1;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b expected 0", imem_req); end checks++;
        @(negedge clk);
        rst_n = 1'b1; resp_en = 1'b1;
        #1;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_restart_req: got %b expected 1", imem_req); end checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_addr: got %h expected 00000000", imem_addr); end checks++;
        @(negedge clk);
        imem_gnt = 1'b1;
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_late_ov: got %b expected 0", out_valid); end checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_late_req: got %b expected 1", imem_req); end checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_late_addr: got %h expected 00000000", imem_addr); end checks++;
        @(negedge clk);
        #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ov_c4: got %b expected 0", out_valid); end checks++;
        if (imem_addr !== 32'h4) begin errors++; $display("FAIL mid_addr_c4: got %h expected 00000004", imem_addr); end checks++;
        @(negedge clk);
        #1;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_ov: got %b expected 1", out_valid); end checks++;
        if (out_pc !== 32'h0) begin errors++; $display("FAIL mid_new_pc: got %h expected 00000000", out_pc); end checks++;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0; imem_gnt = 1'b1;
        #1;
        if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_addr: got %h expected fffffffc", imem_addr); end checks++;
        @(negedge clk);
        imem_gnt = 1'b0;
        #1;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req: got %b expected 1", imem_req); end checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); end checks++;
        @(negedge clk);
        resp_en = 1'b1;
        @(negedge clk);
        #1;
        if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out_pc: got %h expected fffffffc", out_pc); end checks++;
        if (out_instr !== word_at(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_out_instr: got %h expected %h", out_instr, word_at(32'hFFFF_FFFC)); end checks++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_decode();
        test_reset_midop();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
